// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// pipe_ctrl : per-boundary stall/flush control, exception drain/flush/refill
//             sequencing and a stall watchdog.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl #(
  parameter int REFILL_CYCLES = 2,
  parameter int WDOG_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic        div_busy,
  input  logic        dcache_miss,
  input  logic        mem_pending,
  input  logic        br_flush,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  output logic        pc_stall,
  output logic [3:0]  stall,
  output logic [3:0]  flash,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        wdog_err
);

  localparam int RW    = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam int RLOAD = (REFILL_CYCLES > 0) ? REFILL_CYCLES - 1 : 0;
  localparam int WW    = $clog2(WDOG_LIMIT + 1);
  localparam logic [RW-1:0] REFILL_LOAD = RW'(RLOAD);
  localparam logic [WW-1:0] WDOG_MAX    = WW'(WDOG_LIMIT);
  localparam logic [WW-1:0] WDOG_PRE    = WW'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REFILL = 2'd3
  } state_t;

  state_t          state;
  logic [31:0]     target;
  logic [RW-1:0]   refill_cnt;
  logic [WW-1:0]   wdog_cnt;
  logic            wdog_flag;

  assign wdog_err = wdog_flag;

  always_comb begin
    pc_stall       = 1'b0;
    stall          = 4'h0;
    flash          = 4'h0;
    redirect_valid = 1'b0;
    redirect_pc    = target;
    busy           = (state != ST_RUN);
    if (rst) begin
      flash = 4'hF;
      busy  = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_req) begin
            stall    = 4'hF;
            pc_stall = 1'b1;
          end else begin
            // The highest stalled stage takes a bubble; everything younger holds.
            if (dcache_miss) begin
              stall    = 4'b0111;
              flash    = 4'b1000;
              pc_stall = 1'b1;
            end else if (div_busy) begin
              stall    = 4'b0011;
              flash    = 4'b0100;
              pc_stall = 1'b1;
            end else if (icache_miss) begin
              flash    = 4'b0001;
              pc_stall = 1'b1;
            end
            // A stalled EX/MEM keeps the branch in EX, so it is replayed later.
            if (br_flush && !dcache_miss && !div_busy) begin
              flash[1:0]     = 2'b11;
              stall[0]       = 1'b0;
              redirect_valid = 1'b1;
              redirect_pc    = br_target;
            end
          end
        end
        ST_DRAIN: begin
          stall    = 4'hF;
          pc_stall = 1'b1;
        end
        ST_FLUSH: begin
          flash          = 4'hF;
          redirect_valid = 1'b1;
        end
        default: begin
          pc_stall = 1'b1;
          flash    = 4'b0001;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      target     <= 32'h0;
      refill_cnt <= '0;
      wdog_cnt   <= '0;
      wdog_flag  <= 1'b0;
    end else begin
      if (pc_stall) begin
        if (wdog_cnt != WDOG_MAX) begin
          wdog_cnt <= wdog_cnt + 1'b1;
          if (wdog_cnt == WDOG_PRE) wdog_flag <= 1'b1;
        end
      end else begin
        wdog_cnt <= '0;
      end

      case (state)
        ST_RUN: begin
          if (exc_req) begin
            target <= exc_target;
            state  <= mem_pending ? ST_DRAIN : ST_FLUSH;
          end
        end
        ST_DRAIN: begin
          if (!mem_pending) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          refill_cnt <= REFILL_LOAD;
          state      <= (REFILL_CYCLES > 0) ? ST_REFILL : ST_RUN;
        end
        default: begin
          if (refill_cnt == '0) state <= ST_RUN;
          else refill_cnt <= refill_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipe_ctrl : directed + randomized checks of pipe_ctrl against a model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

  localparam int REFILL = 2;
  localparam int WDOG   = 8;

  logic        clk = 1'b0;
  logic        rst, icache_miss, div_busy, dcache_miss, mem_pending, br_flush, exc_req;
  logic [31:0] br_target, exc_target;
  logic        pc_stall, redirect_valid, busy, wdog_err;
  logic [3:0]  stall, flash;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_drain, m_flush;
  int          m_refill, m_wcnt;
  bit          m_err;
  logic [31:0] m_target;

  // expected outputs of the current cycle
  logic        e_pc, e_rv, e_busy;
  logic [3:0]  e_stall, e_flash;
  logic [31:0] e_rpc;

  pipe_ctrl #(.REFILL_CYCLES(REFILL), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst(rst), .icache_miss(icache_miss), .div_busy(div_busy),
    .dcache_miss(dcache_miss), .mem_pending(mem_pending), .br_flush(br_flush),
    .br_target(br_target), .exc_req(exc_req), .exc_target(exc_target),
    .pc_stall(pc_stall), .stall(stall), .flash(flash),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_outputs();
    int s;
    e_pc = 0; e_rv = 0; e_stall = 0; e_flash = 0; e_rpc = m_target;
    e_busy = m_drain || m_flush || (m_refill > 0);
    if (rst) begin
      e_flash = 4'hF;
      e_busy  = 0;
    end else if (m_drain) begin
      e_stall = 4'hF; e_pc = 1;
    end else if (m_flush) begin
      e_flash = 4'hF; e_rv = 1; e_rpc = m_target;
    end else if (m_refill > 0) begin
      e_pc = 1; e_flash = 4'b0001;
    end else if (exc_req) begin
      e_stall = 4'hF; e_pc = 1;
    end else begin
      s = dcache_miss ? 3 : div_busy ? 2 : icache_miss ? 0 : -1;
      if (s >= 0) begin
        e_pc    = 1;
        e_stall = 4'((1 << s) - 1);
        e_flash = 4'(1 << s);
      end
      if (br_flush && s < 2) begin
        e_flash = e_flash | 4'b0011;
        e_stall = e_stall & 4'b1110;
        e_rv    = 1;
        e_rpc   = br_target;
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_drain = 0; m_flush = 0; m_refill = 0; m_wcnt = 0; m_err = 0; m_target = 0;
    end else begin
      if (e_pc) begin
        if (m_wcnt < WDOG) m_wcnt++;
        if (m_wcnt == WDOG) m_err = 1;
      end else begin
        m_wcnt = 0;
      end
      if (m_drain) begin
        if (!mem_pending) begin m_drain = 0; m_flush = 1; end
      end else if (m_flush) begin
        m_flush = 0; m_refill = REFILL;
      end else if (m_refill > 0) begin
        m_refill--;
      end else if (exc_req) begin
        m_target = exc_target;
        if (mem_pending) m_drain = 1; else m_flush = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, compare every output against the model, clock it.
  task automatic step(input logic r, input logic ic, input logic dv, input logic dc,
                      input logic mp, input logic bf, input logic [31:0] bt,
                      input logic ex, input logic [31:0] et);
    @(negedge clk);
    rst = r; icache_miss = ic; div_busy = dv; dcache_miss = dc; mem_pending = mp;
    br_flush = bf; br_target = bt; exc_req = ex; exc_target = et;
    #1;
    model_outputs();
    check("stall", 32'(stall), 32'(e_stall));
    check("flash", 32'(flash), 32'(e_flash));
    check("pc_stall", 32'(pc_stall), 32'(e_pc));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("busy", 32'(busy), 32'(e_busy));
    if (!r) check("wdog_err", 32'(wdog_err), 32'(m_err));
    if (e_rv) check("redirect_pc", redirect_pc, e_rpc);
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    m_drain = 0; m_flush = 0; m_refill = 0; m_wcnt = 0; m_err = 0; m_target = 0;

    // reset for two cycles
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("rst_flash", 32'(flash), 32'hF);
    step(1, 1, 1, 1, 1, 1, 32'h1234, 1, 32'h5678);
    check("rst_stall", 32'(stall), 32'h0);
    idle(1);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_wdog", 32'(wdog_err), 32'h0);
    check("post_rst_rpc", redirect_pc, 32'h0);

    // stall priority
    step(0, 0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    check("dc_div_stall", 32'(stall), 32'h7);
    check("dc_div_flash", 32'(flash), 32'h8);
    step(0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    check("div_stall", 32'(stall), 32'h3);
    check("div_flash", 32'(flash), 32'h4);

    // branch redirect, then blocked by div_busy
    step(0, 0, 0, 0, 0, 1, 32'hBFC0_0100, 0, 32'h0);
    check("br_flash", 32'(flash), 32'h3);
    check("br_rpc", redirect_pc, 32'hBFC0_0100);
    step(0, 0, 1, 0, 0, 1, 32'hBFC0_0100, 0, 32'h0);
    check("br_div_rv", 32'(redirect_valid), 32'h0);
    step(0, 1, 0, 0, 0, 1, 32'hBFC0_0200, 0, 32'h0);
    idle(1);

    // exception with three cycles of mem_pending
    step(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h8000_0180);
    step(0, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    step(0, 1, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("drain_stall", 32'(stall), 32'hF);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("flush_flash", 32'(flash), 32'hF);
    check("flush_rpc", redirect_pc, 32'h8000_0180);
    step(0, 0, 0, 0, 0, 1, 32'h1111_0000, 0, 32'h0);
    check("refill_rv", 32'(redirect_valid), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hDEAD_0000);
    idle(1);
    check("run_busy", 32'(busy), 32'h0);

    // exception and branch together; exception with dcache_miss
    step(0, 0, 0, 0, 0, 1, 32'h2222_0000, 1, 32'h8000_0200);
    check("exc_br_rv", 32'(redirect_valid), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("exc_br_rpc", redirect_pc, 32'h8000_0200);
    idle(3);
    step(0, 0, 0, 1, 0, 0, 32'h0, 1, 32'h8000_0300);
    check("exc_dc_stall", 32'(stall), 32'hF);
    idle(4);

    // reset in the middle of DRAIN
    step(0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h8000_0400);
    step(0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    check("drain_rst_rv", 32'(redirect_valid), 32'h0);
    idle(2);

    // watchdog: 7 stalled cycles then a gap keeps it clear
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(1);
    check("wdog_7", 32'(wdog_err), 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(1);
    check("wdog_8", 32'(wdog_err), 32'h1);
    idle(3);
    check("wdog_sticky", 32'(wdog_err), 32'h1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle(1);
    check("wdog_rst", 32'(wdog_err), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 11) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
